// File: rtl/decoder3_8_seq_if.sv
// Push-side handshake for decoder3_8_seq: a 3-bit code {x,y,z} offered with valid/ready.
interface decoder3_8_seq_if;
    logic in_valid;
    logic in_ready;
    logic x;
    logic y;
    logic z;

    modport master (output in_valid, output x, output y, output z, input in_ready);
    modport slave  (input in_valid, input x, input y, input z, output in_ready);
endinterface

// File: rtl/decoder3_8_seq.sv
// Sequenced 3-to-8 decoder: queues codes in a small FIFO and replays each as a
// one-hot strobe of programmable length, followed by a single all-zero gap cycle.
module decoder3_8_seq #(
    parameter int WIDTH    = 8,
    parameter int WIDTH_IN = 3,
    parameter int DEPTH    = 4,
    parameter int HOLD_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    decoder3_8_seq_if.slave            bus,
    input  logic                       en,
    input  logic [HOLD_W-1:0]          hold,
    output logic [WIDTH-1:0]           D,
    output logic [WIDTH_IN-1:0]        d_code,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [WIDTH_IN-1:0] r_mem [DEPTH];
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [CW-1:0]       r_count;
    logic [1:0]          r_state;
    logic [HOLD_W-1:0]   r_cnt;
    logic [WIDTH-1:0]    r_d;
    logic [WIDTH_IN-1:0] r_code;

    logic                w_ready;
    logic                w_push;
    logic                w_pop;
    logic [WIDTH_IN-1:0] w_code_in;
    logic [WIDTH_IN-1:0] w_head;
    logic [HOLD_W-1:0]   w_hold_m1;

    // Ready comes only from registered occupancy; a pop in the same cycle does not free a slot early.
    assign w_ready   = (r_count != CW'(DEPTH));
    assign w_push    = bus.in_valid && w_ready;
    assign w_pop     = ((r_state == S_IDLE) || (r_state == S_GAP)) && (r_count != '0) && en;
    assign w_code_in = WIDTH_IN'({bus.x, bus.y, bus.z});
    assign w_head    = r_mem[r_rptr];
    assign w_hold_m1 = (hold == '0) ? '0 : hold - HOLD_W'(1);

    assign bus.in_ready = w_ready;
    assign D            = r_d;
    assign d_code       = r_code;
    assign busy         = (r_state != S_IDLE);
    assign count        = r_count;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= w_code_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_d     <= '0;
            r_code  <= '0;
        end else begin
            case (r_state)
                S_DRIVE: begin
                    if (r_cnt == '0) begin
                        r_state <= S_GAP;
                        r_d     <= '0;
                        r_code  <= '0;
                    end else begin
                        r_cnt <= r_cnt - HOLD_W'(1);
                    end
                end
                // IDLE and GAP share the pop path; GAP falls back to IDLE when nothing can pop.
                default: begin
                    if (w_pop) begin
                        r_state <= S_DRIVE;
                        r_d     <= WIDTH'(1) << w_head;
                        r_code  <= w_head;
                        r_cnt   <= w_hold_m1;
                    end else begin
                        r_state <= S_IDLE;
                        r_d     <= '0;
                        r_code  <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_decoder3_8_seq.sv
// Directed-vector bench for decoder3_8_seq; each scenario task checks its own expected values.
module tb_decoder3_8_seq;
    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] hold;
    logic [7:0] D;
    logic [2:0] d_code;
    logic       busy;
    logic [2:0] count;

    int nvec = 0;
    int nerr = 0;

    decoder3_8_seq_if bus ();

    decoder3_8_seq #(.WIDTH(8), .WIDTH_IN(3), .DEPTH(4), .HOLD_W(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .en     (en),
        .hold   (hold),
        .D      (D),
        .d_code (d_code),
        .busy   (busy),
        .count  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference 8:3 priority encoder used for the round-trip check.
    function automatic logic [2:0] enc8(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int k = 0; k < 8; k++)
            if (v[k]) r = 3'(k);
        return r;
    endfunction

    task automatic push(input logic [2:0] c);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        {bus.x, bus.y, bus.z} = c;
        for (int i = 0; i < 60; i++) begin
            if (bus.in_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1 bus.in_valid = 1'b0;
        nvec++;
        if (!ok) begin
            nerr++;
            $display("FAIL push_timeout code=%0d: in_ready never rose within 60 cycles", c);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        nvec++; if (D !== 8'h00)    begin nerr++; $display("FAIL reset_D got=%h exp=00", D); end
        nvec++; if (count !== 3'd0) begin nerr++; $display("FAIL reset_count got=%0d exp=0", count); end
        nvec++; if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready got=%b exp=1", bus.in_ready); end
        nvec++; if (busy !== 1'b0)  begin nerr++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        hold = 4'd5;
        push(3'd3);
        push(3'd7);
        @(negedge clk);
        nvec++; if (D !== 8'h08) begin nerr++; $display("FAIL prereset_D got=%h exp=08", D); end
        nvec++; if (count !== 3'd1) begin nerr++; $display("FAIL prereset_count got=%0d exp=1", count); end
        #2 rst_n = 1'b0;
        #1;
        nvec++; if (D !== 8'h00)    begin nerr++; $display("FAIL midreset_D got=%h exp=00", D); end
        nvec++; if (d_code !== 3'd0) begin nerr++; $display("FAIL midreset_dcode got=%0d exp=0", d_code); end
        nvec++; if (count !== 3'd0) begin nerr++; $display("FAIL midreset_count got=%0d exp=0", count); end
        nvec++; if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL midreset_ready got=%b exp=1", bus.in_ready); end
        nvec++; if (busy !== 1'b0)  begin nerr++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            nvec++;
            if (D !== 8'h00 || count !== 3'd0) begin
                nerr++; $display("FAIL idle_after_reset cyc=%0d D=%h count=%0d exp D=00 count=0", i, D, count);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] eD [6]  = '{8'h00, 8'h20, 8'h20, 8'h20, 8'h00, 8'h00};
        logic [2:0] eC [6]  = '{3'd0, 3'd5, 3'd5, 3'd5, 3'd0, 3'd0};
        logic       eB [6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        en = 1'b1;
        hold = 4'd3;
        push(3'b101);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            nvec++;
            if (D !== eD[i] || d_code !== eC[i] || busy !== eB[i]) begin
                nerr++;
                $display("FAIL single cyc=%0d D=%h code=%0d busy=%b exp D=%h code=%0d busy=%b",
                         i, D, d_code, busy, eD[i], eC[i], eB[i]);
            end
        end
    endtask

    task automatic test_sweep_hold0();
        en = 1'b1;
        hold = 4'd0;
        fork
            begin
                for (int c = 0; c < 8; c++) push(3'(c));
            end
            begin
                int w;
                logic [7:0] e;
                w = 0;
                @(negedge clk);
                while (D === 8'h00 && w < 20) begin @(negedge clk); w++; end
                nvec++;
                if (w >= 20) begin nerr++; $display("FAIL sweep_start D stayed %h, exp nonzero", D); end
                for (int i = 0; i < 16; i++) begin
                    e = (i % 2 == 0) ? (8'h01 << (i / 2)) : 8'h00;
                    nvec++;
                    if (D !== e) begin nerr++; $display("FAIL sweep_D step=%0d got=%h exp=%h", i, D, e); end
                    if (i % 2 == 0) begin
                        nvec++;
                        if (enc8(D) !== 3'(i / 2) || d_code !== 3'(i / 2)) begin
                            nerr++; $display("FAIL sweep_roundtrip step=%0d enc=%0d code=%0d exp=%0d", i, enc8(D), d_code, i / 2);
                        end
                    end
                    @(negedge clk);
                end
            end
        join
        repeat (3) @(negedge clk);
    endtask

    task automatic test_full();
        logic [7:0] eD [10] = '{8'h02, 8'h00, 8'h04, 8'h00, 8'h08, 8'h00, 8'h10, 8'h00, 8'h40, 8'h00};
        en = 1'b0;
        hold = 4'd1;
        fork
            begin
                push(3'd1); push(3'd2); push(3'd3); push(3'd4); push(3'd6);
            end
            begin
                repeat (8) @(negedge clk);
                nvec++; if (count !== 3'd4) begin nerr++; $display("FAIL full_count got=%0d exp=4", count); end
                nvec++; if (bus.in_ready !== 1'b0) begin nerr++; $display("FAIL full_ready got=%b exp=0", bus.in_ready); end
                nvec++; if (D !== 8'h00) begin nerr++; $display("FAIL full_D got=%h exp=00", D); end
                en = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    nvec++;
                    if (D !== eD[i]) begin nerr++; $display("FAIL full_order step=%0d got=%h exp=%h", i, D, eD[i]); end
                    if (i == 1) begin
                        nvec++;
                        if (count !== 3'd4) begin nerr++; $display("FAIL full_refill count=%0d exp=4", count); end
                    end
                end
            end
        join
        repeat (2) @(negedge clk);
    endtask

    task automatic test_en_drop();
        en = 1'b0;
        hold = 4'd4;
        push(3'd3);
        push(3'd6);
        @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 1) en = 1'b0;
            nvec++;
            if (D !== 8'h08) begin nerr++; $display("FAIL endrop_strobe cyc=%0d got=%h exp=08", i, D); end
        end
        @(negedge clk);
        nvec++;
        if (D !== 8'h00 || busy !== 1'b1) begin nerr++; $display("FAIL endrop_gap D=%h busy=%b exp D=00 busy=1", D, busy); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            nvec++;
            if (D !== 8'h00 || busy !== 1'b0 || count !== 3'd1) begin
                nerr++; $display("FAIL endrop_idle cyc=%0d D=%h busy=%b count=%0d exp 00/0/1", i, D, busy, count);
            end
        end
        en = 1'b1;
        @(negedge clk);
        nvec++;
        if (D !== 8'h40 || d_code !== 3'd6) begin nerr++; $display("FAIL endrop_resume D=%h code=%0d exp D=40 code=6", D, d_code); end
        repeat (6) @(negedge clk);
        nvec++;
        if (D !== 8'h00 || busy !== 1'b0 || count !== 3'd0) begin
            nerr++; $display("FAIL endrop_drain D=%h busy=%b count=%0d exp 00/0/0", D, busy, count);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] eD [7] = '{8'h04, 8'h04, 8'h00, 8'h04, 8'h04, 8'h00, 8'h00};
        en = 1'b0;
        hold = 4'd2;
        push(3'b010);
        push(3'b010);
        @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            nvec++;
            if (D !== eD[i]) begin nerr++; $display("FAIL repeat_code step=%0d got=%h exp=%h", i, D, eD[i]); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        hold = 4'd0;
        bus.in_valid = 1'b0;
        bus.x = 1'b0;
        bus.y = 1'b0;
        bus.z = 1'b0;
        test_reset();
        test_single();
        test_sweep_hold0();
        test_full();
        test_en_drop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/decoder3_8_seq.md
# decoder3_8_seq

Sequenced 3-to-8 one-hot decoder: accepts 3-bit codes {x,y,z} over a valid/ready handshake, buffers them in a small FIFO, and replays each code as a one-hot strobe on D[7:0] held for a programmable number of cycles, followed by one all-zero gap cycle. It sits on the output side of the one-hot/binary interface, turning binary select codes back into timed one-hot enables for downstream lines.

## Interface

- WIDTH, 8: one-hot output width; must equal 2**WIDTH_IN.
- WIDTH_IN, 3: code width.
- DEPTH, 4: FIFO depth in entries; power of 2, at least 2.
- HOLD_W, 4: width of the hold-length input.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  code presented on x,y,z.
- in_ready  output  1  FIFO can accept; equals (count != DEPTH).
- x  input  1  code MSB (bit 2).
- y  input  1  code bit 1.
- z  input  1  code LSB (bit 0).
- en  input  1  permits popping a new code; does not stop a pulse in progress.
- hold  input  HOLD_W  strobe length in cycles, sampled at pop; 0 is treated as 1.
- D  output  WIDTH  one-hot strobe, registered; all-zero when not driving.
- d_code  output  WIDTH_IN  code currently driven, registered; 0 when not driving.
- busy  output  1  high in DRIVE or GAP.
- count  output  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

## Operation

- Push: in_valid && in_ready at a rising edge writes {x,y,z} into the FIFO tail.
- in_ready is derived only from registered count. There is no same-cycle pass-through when full, even if a pop occurs in that cycle.
- FSM states: IDLE, DRIVE, GAP.
- IDLE: if count != 0 and en == 1, pop the head on the next edge.
  - D = 1 << code, d_code = code.
  - Load cnt = max(hold,1) - 1.
  - Go to DRIVE.
  - Otherwise stay in IDLE with D = 0.
- DRIVE: if cnt == 0, go to GAP with D = 0 and d_code = 0. Otherwise decrement cnt and keep D.
- GAP: exactly one cycle, D = 0.
  - If count != 0 and en == 1, pop directly into DRIVE.
  - Otherwise go to IDLE.
- Simultaneous push and pop: the pop takes the current head. count is unchanged. When count == 0, a push and a pop cannot coincide because the pop needs registered count != 0.
- en falling mid-pulse: the current strobe completes its full length plus its gap, and no further pop occurs. FIFO contents are retained.
- FIFO pointers wrap modulo DEPTH. count saturates logically at DEPTH because in_ready blocks further pushes.
- D is always zero-hot or one-hot; it is never multi-hot.

## Timing

- Reset (asynchronous, immediate):
  - D = 0, d_code = 0, busy = 0.
  - count = 0, in_ready = 1.
  - State = IDLE, FIFO pointers = 0, cnt = 0.
- Reset asserted mid-pulse clears D in the same instant and discards all queued codes.
- Latency: a code accepted at edge N into an empty FIFO, with the FSM in IDLE and en = 1, appears on D after edge N+1.
- Strobe width is max(hold,1) cycles, then a 1-cycle gap.
- Back-to-back throughput is one code per max(hold,1) + 1 cycles.
- count updates at the push/pop edge. in_ready falls in the cycle after the edge that makes count == DEPTH.
- busy = 1 from the edge that enters DRIVE until the edge that leaves GAP to IDLE.

## Test plan

- Reset then idle: rst_n low mid-run -> D = 0, count = 0, in_ready = 1 immediately. With no pushes after release, D stays 0.
- Single code: push 3'b101 with hold = 3 at edge N -> D = 8'h20 and d_code = 5 for edges N+1..N+3, D = 0 at N+4, busy = 0 after N+5.
- Hold zero and sweep: push codes 0..7 with hold = 0 -> D = 01, 00, 02, 00, 04, …, 80, 00, with each one-hot value lasting 1 cycle. Each code round-trips through the team's 8:3 priority encoder to its input value.
- Full FIFO: en = 0, push 5 codes continuously -> 4 accepted, in_ready = 0 with count = 4, the 5th is held. Raise en -> the 5th is accepted on the edge after the first pop, and order is preserved.
- en drop mid-pulse: hold = 4, en falls after 2 strobe cycles -> the strobe lasts 4 cycles plus the gap, then IDLE. The next queued code is output only after en returns.
- Same code repeated: push 3'b010 twice with hold = 2 -> D = 04, 04, 00, 04, 04, 00; the gap makes the two strobes distinguishable.
